// File: rtl/vga_pkg.sv
// Shared VGA scanout types, 640x480@60 default timing and framebuffer sizing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

   localparam int DEF_H_ACTIVE    = 640;
   localparam int DEF_H_FP        = 16;
   localparam int DEF_H_SYNC      = 96;
   localparam int DEF_H_BP        = 48;
   localparam int DEF_V_ACTIVE    = 480;
   localparam int DEF_V_FP        = 10;
   localparam int DEF_V_SYNC      = 2;
   localparam int DEF_V_BP        = 33;
   localparam int DEF_SCALE_SHIFT = 2;

   // Framebuffer word: 4R:4G:4B, red in the MSBs
   localparam int PXL_W = 12;

   typedef struct packed {
      logic       hsync;
      logic       vsync;
      logic [3:0] red;
      logic [3:0] green;
      logic [3:0] blue;
   } vga_out_t;

   // Pins while idle: syncs deasserted (active-low), colour black
   localparam vga_out_t VGA_IDLE = '{hsync: 1'b1, vsync: 1'b1, red: 4'h0, green: 4'h0, blue: 4'h0};

   // Address width needed for a framebuffer of (h>>s) x (v>>s) words
   function automatic int fb_addr_w(int h, int v, int s);
      return $clog2((h >> s) * (v >> s));
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster h/v counters with sync decode, active-region flag and frame status strobes.
// Latency: all outputs combinational from the counter registers.
// Backpressure: none; free-running while enabled, held at (0,0) otherwise.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int H_CNT_W  = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   parameter int V_CNT_W  = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_enable,
   output logic [H_CNT_W-1:0] o_h,
   output logic [V_CNT_W-1:0] o_v,
   output logic               o_run,
   output logic               o_lineEnd,
   output logic               o_active,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_frameStart,
   output logic               o_vblank
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(H_TOTAL - 1);
   localparam logic [H_CNT_W-1:0] H_ACT  = H_CNT_W'(H_ACTIVE);
   localparam logic [H_CNT_W-1:0] HS_BEG = H_CNT_W'(H_ACTIVE + H_FP);
   localparam logic [H_CNT_W-1:0] HS_END = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_CNT_W-1:0] V_LAST = V_CNT_W'(V_TOTAL - 1);
   localparam logic [V_CNT_W-1:0] V_ACT  = V_CNT_W'(V_ACTIVE);
   localparam logic [V_CNT_W-1:0] VS_BEG = V_CNT_W'(V_ACTIVE + V_FP);
   localparam logic [V_CNT_W-1:0] VS_END = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [H_CNT_W-1:0] h;
   logic [V_CNT_W-1:0] v;
   logic               run;

   // Reset takes priority over enable; both park the raster at (0,0)
   assign run = i_enable && !i_reset;

   // Raster position: h wraps every line, v advances on each h wrap
   always_ff @(posedge i_clk) begin
      if (!run) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + V_CNT_W'(1);
      end else begin
         h <= h + H_CNT_W'(1);
      end
   end

   assign o_h          = h;
   assign o_v          = v;
   assign o_run        = run;
   assign o_lineEnd    = run && (h == H_LAST);
   assign o_active     = run && (h < H_ACT) && (v < V_ACT);
   assign o_hsync      = !((h >= HS_BEG) && (h < HS_END));
   assign o_vsync      = !((v >= VS_BEG) && (v < VS_END));
   assign o_frameStart = run && (h == '0) && (v == '0);
   assign o_vblank     = run && (v >= V_ACT);

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer reader: one read per active pixel, syncs re-aligned to returned data, registered VGA pins.
// Latency: RD_LAT+1 cycles from counter state to pins; status outputs are undelayed.
// Backpressure: none; read port is fixed-latency and must return data RD_LAT cycles after o_fbRdEn.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP,
   parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
   parameter int RD_LAT      = 1,
   parameter int FB_ADDR_W   = fb_addr_w(H_ACTIVE, V_ACTIVE, SCALE_SHIFT)
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_enable,
   output logic [FB_ADDR_W-1:0] o_fbAddr,
   output logic                 o_fbRdEn,
   input  logic [PXL_W-1:0]     i_fbData,
   output vga_out_t             o_vgaData,
   output logic                 o_frameStart,
   output logic                 o_vblank
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_CNT_W = $clog2(H_TOTAL);
   localparam int V_CNT_W = $clog2(V_TOTAL);

   localparam logic [V_CNT_W-1:0]   V_LAST   = V_CNT_W'(V_TOTAL - 1);
   localparam logic [V_CNT_W-1:0]   V_ACT    = V_CNT_W'(V_ACTIVE);
   localparam logic [V_CNT_W-1:0]   ROW_MASK = V_CNT_W'((1 << SCALE_SHIFT) - 1);
   localparam logic [FB_ADDR_W-1:0] FB_W     = FB_ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

   logic [H_CNT_W-1:0]   h;
   logic [V_CNT_W-1:0]   v;
   logic [V_CNT_W-1:0]   v_nxt;
   logic                 run;
   logic                 line_end;
   logic                 active;
   logic                 hsync_c;
   logic                 vsync_c;
   logic                 row_step;
   logic [FB_ADDR_W-1:0] row_base;
   logic [RD_LAT-1:0]    act_pipe;
   logic [RD_LAT-1:0]    hs_pipe;
   logic [RD_LAT-1:0]    vs_pipe;
   logic [PXL_W-1:0]     pix;

   vga_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .H_CNT_W  (H_CNT_W),
      .V_CNT_W  (V_CNT_W)
   ) u_timing (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .o_h          (h),
      .o_v          (v),
      .o_run        (run),
      .o_lineEnd    (line_end),
      .o_active     (active),
      .o_hsync      (hsync_c),
      .o_vsync      (vsync_c),
      .o_frameStart (o_frameStart),
      .o_vblank     (o_vblank)
   );

   // Next raster line starts a new framebuffer row every 2^SCALE_SHIFT lines inside the visible area
   assign v_nxt    = v + V_CNT_W'(1);
   assign row_step = ((v_nxt & ROW_MASK) == '0) && (v_nxt < V_ACT);

   // Row base address tracks v>>SCALE_SHIFT times row width by accumulation, no multiplier
   always_ff @(posedge i_clk) begin
      if (!run) begin
         row_base <= '0;
      end else if (line_end) begin
         if (v == V_LAST) begin
            row_base <= '0;
         end else if (row_step) begin
            row_base <= row_base + FB_W;
         end
      end
   end

   assign o_fbRdEn = active;
   assign o_fbAddr = active ? row_base + FB_ADDR_W'(h >> SCALE_SHIFT) : '0;

   // Delay active and syncs by the read latency so they line up with returned data
   always_ff @(posedge i_clk) begin
      if (!run) begin
         act_pipe <= '0;
         hs_pipe  <= '1;
         vs_pipe  <= '1;
      end else begin
         act_pipe[0] <= active;
         hs_pipe[0]  <= hsync_c;
         vs_pipe[0]  <= vsync_c;
         for (int i = 1; i < RD_LAT; i++) begin
            act_pipe[i] <= act_pipe[i-1];
            hs_pipe[i]  <= hs_pipe[i-1];
            vs_pipe[i]  <= vs_pipe[i-1];
         end
      end
   end

   // Read data is ignored outside the active region, so stale bus values never reach the pins
   assign pix = act_pipe[RD_LAT-1] ? i_fbData : '0;

   // Pin register: one extra cycle after the aligned pipeline tap
   always_ff @(posedge i_clk) begin
      if (!run) begin
         o_vgaData <= VGA_IDLE;
      end else begin
         o_vgaData <= '{hsync: hs_pipe[RD_LAT-1],
                        vsync: vs_pipe[RD_LAT-1],
                        red:   pix[11:8],
                        green: pix[7:4],
                        blue:  pix[3:0]};
      end
   end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Reads back the framebuffer that the core writes through memory-mapped pixel stores, and generates VGA timing. The core side is the writer; this block is the reader.
- Walks fixed 640x480@60 raster counters.
- Issues one framebuffer read per active pixel on a fixed-latency read port.
- Re-aligns syncs and blanking to the returned data and drives the vga_out_t bundle.
- Sits in the vga_clk domain, between the framebuffer read port and the VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
SCALE_SHIFT, 2, log2 pixel replication; framebuffer is 160x120
PXL_W, 12, framebuffer word width (4R:4G:4B, red in MSBs)
RD_LAT, 1, framebuffer read latency in cycles (1..3)
FB_ADDR_W, 15, framebuffer address width

Ports:
i_clk  in  1  pixel clock (vga_clk)
i_reset  in  1  synchronous reset, active-high
i_enable  in  1  scanout enable
o_fbAddr  out  FB_ADDR_W  framebuffer read address
o_fbRdEn  out  1  framebuffer read strobe
i_fbData  in  PXL_W  read data, valid RD_LAT cycles after o_fbRdEn
o_vgaData  out  vga_out_t  {hsync, vsync, red[3:0], green[3:0], blue[3:0]}
o_frameStart  out  1  one-cycle pulse at raster (0,0)
o_vblank  out  1  high while raster line >= V_ACTIVE

Behaviour:
Interface (already decided):
- One clock, i_clk.
- i_reset is synchronous and active-high.

Raster counters:
- h counts 0..H_TOTAL-1, with H_TOTAL = sum of the H_* parameters = 800.
- v counts 0..V_TOTAL-1 = 524 and increments when h wraps.
- (799,524) wraps to (0,0).

Reset and enable:
- Reset, or i_enable low: h=0, v=0, counters held, delay pipeline cleared.
- In that state outputs are: hsync=1, vsync=1, rgb=0, o_fbRdEn=0, o_frameStart=0, o_vblank=0.
- When i_enable rises, counting starts from (0,0) in that cycle.

Active region and read port:
- active = (h < H_ACTIVE) && (v < V_ACTIVE).
- o_fbRdEn = active && i_enable, combinational from the counter registers.
- o_fbAddr is valid when o_fbRdEn=1 and is 0 when it is low.
- Address = rowBase + (h >> SCALE_SHIFT).
- rowBase is a register with no multiplier:
  - cleared at v=0;
  - increases by FB_W = H_ACTIVE >> SCALE_SHIFT (160) at each h wrap where (v+1)[SCALE_SHIFT-1:0] == 0 and v+1 < V_ACTIVE.

Sync timing (counter domain, both active-low):
- hsync low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656,752).
- vsync low for v in [490,492).

Output alignment:
- active, hsync and vsync pass through an RD_LAT-deep shift register.
- o_vgaData is then registered, so total latency from counter state to pins is RD_LAT+1 cycles.
- Colour = delayed-active ? i_fbData fields : 0.
- Data is never used when delayed-active is 0.

Status outputs (combinational from counters, not delayed):
- o_frameStart = i_enable && h==0 && v==0.
- o_vblank = i_enable && v >= V_ACTIVE.

Boundary conditions:
- Reset mid-frame: the next cycle matches the reset state, and no stale pipeline pixel reaches the pins.
- i_enable falling mid-line: same as reset.
- A frame is exactly 800*525 = 420000 cycles.

Decomposition:
- Package vga_pkg holds:
  - vga_out_t;
  - the 640x480 timing constants, as defaults;
  - PXL_W;
  - function fb_addr_w(H,V,S).
- Sub-module vga_timing holds the h/v counters, sync decode, active, o_frameStart and o_vblank.
- vga_scanout adds the address generator, delay pipeline and output register.

Test Plan:
- Reset: assert i_reset for 3 cycles mid-frame -> all outputs at reset values the cycle after the first reset edge; raster restarts at (0,0) on release.
- Sync timing: enable at cycle 0 with RD_LAT=1 -> pin hsync low from cycle 658 for 96 cycles, period 800; pin vsync low for 1600 cycles starting at cycle 490*800+2.
- Addressing, line 0: h=0..3 -> addr 0; h=4 -> 1; h=639 -> 159.
- Addressing, further lines: v=3,h=0 -> addr 0; v=4,h=0 -> 160; v=479,h=639 -> 19199.
- Data path: framebuffer model returns data = addr[11:0] after RD_LAT cycles, swept RD_LAT=1,2,3 -> each pin rgb equals the address issued RD_LAT+1 cycles earlier.
- Blanking: rgb=0 and o_fbRdEn=0 at h=640..799 and v>=480, even with the model driving 12'hFFF.
- Frame wrap: o_frameStart pulses exactly at cycles 0 and 420000; o_vblank rises at 480*800 and falls at 420000.
